bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3 / double-dabble) downstream of the divider.

---
 rtl/calc_pkg.sv | 22 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 22 ++
 rtl/bin_to_bcd_seq.sv | 125 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// ----------------------------------------------------------------------------
// calc_pkg
// Definitions shared by the calculator datapath blocks: the divider and the
// binary-to-BCD converter that formats its results for the display driver.
//
// Contents:
//   CALC_WIDTH    default width of the unsigned divider results
//   CALC_DIGITS   default number of BCD digits needed to show CALC_WIDTH bits
//   conv_state_t  state encoding of the sequential BCD converter
// ----------------------------------------------------------------------------
package calc_pkg;

    localparam int CALC_WIDTH  = 16;
    localparam int CALC_DIGITS = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CONV = 2'b01,
        S_DONE = 2'b10
    } conv_state_t;

endpackage

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// ----------------------------------------------------------------------------
// bcd_digit_adj
// Single-digit correction step of the shift-and-add-3 algorithm. A digit of
// 5 or more would overflow past 9 when doubled by the next shift, so 3 is
// added first; the shift then carries the excess into the next digit.
//
// Ports:
//   digit_i  in   4   BCD digit before the shift
//   digit_o  out  4   corrected digit, ready to be shifted
// ----------------------------------------------------------------------------
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    // Purely combinational; inputs of 5..9 map to 8..12, which never carry
    // out of the 4-bit digit, so no carry chain to neighbouring digits.
    always_comb begin
        digit_o = (digit_i >= 4'd5) ? (digit_i + 4'd3) : digit_i;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// bin_to_bcd_seq
// Sequential binary-to-BCD converter (double-dabble), one input bit per
// clock. Sits behind the divider: the divider's DONE level drives START, and
// a rising edge on it launches exactly one conversion of BIN.
//
// Ports:
//   CLK    in   1          clock, all state on the rising edge
//   RST    in   1          synchronous, active-high reset
//   START  in   1          level input; a rising edge triggers a conversion
//   BIN    in   WIDTH      unsigned value, sampled on the trigger cycle only
//   BCD    out  4*DIGITS   packed BCD result, digit 0 (units) in BCD[3:0]
//   BUSY   out  1          high while bits are being shifted in
//   DONE   out  1          one-cycle pulse, BCD holds the new result from here
// ----------------------------------------------------------------------------
module bin_to_bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = CALC_DIGITS
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [WIDTH-1:0]      BIN,
    output logic [4*DIGITS-1:0]   BCD,
    output logic                  BUSY,
    output logic                  DONE
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    conv_state_t            state_q, state_d;
    logic                   start_q;
    logic [WIDTH-1:0]       shiftReg_q, shiftReg_d;
    logic [4*DIGITS-1:0]    scratch_q, scratch_d;
    logic [4*DIGITS-1:0]    scratchAdj;
    logic [CNT_W-1:0]       bitCnt_q, bitCnt_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic                   done_q, done_d;
    logic                   trigger;

    // The edge register follows START every cycle, even mid-conversion, so a
    // level still high when the converter returns to idle does not retrigger.
    assign trigger = START & ~start_q;

    // One add-3 corrector per digit of the scratch register.
    for (genvar g = 0; g < DIGITS; g++) begin : gDigit
        bcd_digit_adj uAdj (
            .digit_i (scratch_q[4*g +: 4]),
            .digit_o (scratchAdj[4*g +: 4])
        );
    end

    // State and datapath registers. Reset clears everything, which also
    // aborts a conversion in flight without producing a DONE pulse.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            shiftReg_q <= '0;
            scratch_q  <= '0;
            bitCnt_q   <= '0;
            bcd_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= START;
            shiftReg_q <= shiftReg_d;
            scratch_q  <= scratch_d;
            bitCnt_q   <= bitCnt_d;
            bcd_q      <= bcd_d;
            done_q     <= done_d;
        end
    end

    // Next-state and datapath control. The output BCD register is written
    // only when leaving S_DONE, so the display never sees a partial result.
    // DONE is registered alongside BCD so both change on the same edge.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        scratch_d  = scratch_q;
        bitCnt_d   = bitCnt_q;
        bcd_d      = bcd_q;
        done_d     = 1'b0;
        BUSY       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    shiftReg_d = BIN;
                    scratch_d  = '0;
                    bitCnt_d   = CNT_W'(WIDTH);
                    state_d    = S_CONV;
                end
            end

            S_CONV: begin
                BUSY = 1'b1;
                // Adjust first, then shift the whole {scratch, binary} pair;
                // the top bit of the scratch falls off the end.
                {scratch_d, shiftReg_d} = {scratchAdj, shiftReg_q} << 1;
                bitCnt_d = bitCnt_q - 1'b1;
                if (bitCnt_q == CNT_W'(1)) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                bcd_d   = scratch_q;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign BCD  = bcd_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq. Expected BCD values come from
// decimal arithmetic on the input value; latency and pulse widths are
// measured cycle by cycle relative to the trigger edge.
// ----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;
    localparam int WINDOW = 30;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic [4*DIGITS-1:0]   bcd;
    logic                  busy;
    logic                  done;

    int checkCount;
    int passCount;
    logic [4*DIGITS-1:0] lastBcd;

    bin_to_bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .CLK   (clk),
        .RST   (rst),
        .START (start),
        .BIN   (bin),
        .BCD   (bcd),
        .BUSY  (busy),
        .DONE  (done)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal reference: peel off base-10 digits with plain division.
    function automatic logic [4*DIGITS-1:0] toBcd(input int unsigned value);
        logic [4*DIGITS-1:0] result;
        int unsigned rest;
        result = '0;
        rest   = value;
        for (int d = 0; d < DIGITS; d++) begin
            result[4*d +: 4] = 4'(rest % 10);
            rest = rest / 10;
        end
        return result;
    endfunction

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end else begin
            passCount++;
        end
    endtask

    // Launch one conversion and watch a fixed window after the trigger edge.
    // holdCycles: how long START stays high; scramble: change BIN mid-run;
    // reStart: raise a second START edge while the converter is busy.
    task automatic applyStimulus(input logic [WIDTH-1:0] value, input int holdCycles,
                                 input bit scramble, input bit reStart);
        int latency;
        int busyCycles;
        int firstBusy;
        int doneCycles;
        logic [4*DIGITS-1:0] bcdAtDone;
        logic [4*DIGITS-1:0] expected;

        expected   = toBcd(32'(value));
        latency    = -1;
        firstBusy  = -1;
        busyCycles = 0;
        doneCycles = 0;
        bcdAtDone  = '0;

        @(posedge clk);
        #1;
        bin   = value;
        start = 1'b1;
        @(posedge clk);   // trigger edge T

        for (int c = 0; c < WINDOW; c++) begin
            @(negedge clk);   // follows edge T+c
            if (busy === 1'b1) begin
                busyCycles++;
                if (firstBusy < 0) firstBusy = c;
            end
            if (done === 1'b1) begin
                doneCycles++;
                if (latency < 0) begin
                    latency   = c + 1;
                    bcdAtDone = bcd;
                end
            end
            if (c == 16) checkOutput("bcdHold", 32'(bcd), 32'(lastBcd));
            start = (c + 1 < holdCycles) || (reStart && c >= 4 && c < 6);
            if (scramble && c == 3) bin = WIDTH'($urandom);
        end
        start = 1'b0;

        checkOutput("latency",    32'(latency),    32'd18);
        checkOutput("firstBusy",  32'(firstBusy),  32'd0);
        checkOutput("busyCycles", 32'(busyCycles), 32'd16);
        checkOutput("doneCycles", 32'(doneCycles), 32'd1);
        checkOutput("bcdResult",  32'(bcdAtDone),  32'(expected));
        checkOutput("bcdAfter",   32'(bcd),        32'(expected));
        lastBcd = expected;
    endtask

    // Reset during the eighth conversion cycle must clear outputs at once
    // and suppress any later DONE.
    task automatic resetMidConversion(input logic [WIDTH-1:0] value);
        int doneCycles;
        int busyLate;

        doneCycles = 0;
        busyLate   = 0;

        @(posedge clk);
        #1;
        bin   = value;
        start = 1'b1;
        @(posedge clk);   // trigger edge T

        for (int c = 0; c < WINDOW; c++) begin
            @(negedge clk);
            if (c == 8) begin
                checkOutput("rstBcd",  32'(bcd),  32'd0);
                checkOutput("rstBusy", 32'(busy), 32'd0);
                checkOutput("rstDone", 32'(done), 32'd0);
                rst = 1'b0;
            end
            if (c > 8 && busy === 1'b1) busyLate++;
            if (done === 1'b1) doneCycles++;
            if (c == 0) start = 1'b0;
            if (c == 7) rst = 1'b1;
        end

        checkOutput("rstNoDone", 32'(doneCycles), 32'd0);
        checkOutput("rstNoBusy", 32'(busyLate),   32'd0);
        lastBcd = '0;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        lastBcd    = '0;
        rst        = 1'b1;
        start      = 1'b0;
        bin        = '0;

        if (64'(10) ** DIGITS <= (64'(1) << WIDTH) - 1) begin
            $display("[TB] FAIL digitsRule: DIGITS too small for WIDTH");
            $fatal(1, "[TB] invalid parameters");
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("resetBcd",  32'(bcd),  32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        rst = 1'b0;

        applyStimulus(16'd0,     1,  1'b0, 1'b0);
        applyStimulus(16'd1234,  1,  1'b0, 1'b0);
        applyStimulus(16'hFFFF,  1,  1'b0, 1'b0);
        applyStimulus(16'd9,     1,  1'b0, 1'b0);
        applyStimulus(16'd40960, 31, 1'b1, 1'b0);
        applyStimulus(16'd4321,  1,  1'b0, 1'b1);
        applyStimulus(16'd10000, 1,  1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(WIDTH'($urandom_range(0, 65535)), int'($urandom_range(1, 31)),
                          1'($urandom_range(0, 1)), 1'b0);
        end

        resetMidConversion(16'd54321);
        applyStimulus(16'd777, 1, 1'b0, 1'b0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
